// File: rtl/pipe_pkg.sv
// pipe_pkg: shared forwarding-select encodings and helpers for the pipeline hazard logic
//   FWD_RF / FWD_WB / FWD_MEM : ALU operand source selects
//   REG_ZERO                  : hard-wired zero register number
//   fwd_pick                  : priority encode MEM/WB hits into a select
package pipe_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam int       REG_ZERO = 0;

    // MEM holds the younger write, so it wins over WB
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        return mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
    endfunction

endpackage

// File: rtl/dest_stage_reg.sv
// dest_stage_reg: one pipeline stage copy with async active-low reset and sync clear
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears q
//   clr   : synchronous clear, loads zero instead of d
//   d     : next stage contents
//   q     : held stage contents
module dest_stage_reg #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else        q <= clr ? '0 : d;

endmodule

// File: rtl/dest_reg_tracker.sv
// dest_reg_tracker: carries the RegDst destination through MEM/WB and derives forwarding and load-use stall
//   ex_dest, ex_reg_write, ex_mem_read, ex_flush : instruction leaving EX
//   ex_rs, ex_rt                                  : EX source registers (forwarding compare)
//   id_rs, id_rt, id_uses_rt                      : ID source registers (load-use compare)
//   mem_dest/mem_reg_write, wb_dest/wb_reg_write  : stage copies, wb_* feeds the register-file write port
//   fwd_a, fwd_b                                  : operand A/B source selects
//   stall                                         : load-use hazard request
// Build option: DEST_TRACK_LOAD_USE_EN enables the load-use stall; otherwise stall is 0 and
// mem_read is not stored (software NOP scheduling after loads).
module dest_reg_tracker
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_flush,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  mem_reg_write,
    output logic                  wb_reg_write,
    output fwd_sel_t              fwd_a,
    output fwd_sel_t              fwd_b,
    output logic                  stall
);

    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

    logic [REG_ADDR_W:0] wb_q;
    logic                unused_ok;

`ifdef DEST_TRACK_LOAD_USE_EN
    logic [REG_ADDR_W+1:0] mem_q;
    logic                  mem_read;

    dest_stage_reg #(.W(REG_ADDR_W + 2)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ex_flush),
        .d     ({ex_dest, ex_reg_write, ex_mem_read}),
        .q     (mem_q)
    );

    assign {mem_dest, mem_reg_write, mem_read} = mem_q;
    // the stored load flag is kept for the stage record but nothing downstream consumes it yet
    assign unused_ok = mem_read;
    // stall is held low during reset and for a squashed instruction
    assign stall = rst_n && !ex_flush && ex_mem_read && ex_reg_write && ex_dest != ZERO &&
                   (ex_dest == id_rs || (id_uses_rt && ex_dest == id_rt));
`else
    logic [REG_ADDR_W:0] mem_q;

    dest_stage_reg #(.W(REG_ADDR_W + 1)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ex_flush),
        .d     ({ex_dest, ex_reg_write}),
        .q     (mem_q)
    );

    assign {mem_dest, mem_reg_write} = mem_q;
    assign unused_ok = ^{ex_mem_read, id_rs, id_rt, id_uses_rt};
    assign stall = 1'b0;
`endif

    // WB never freezes: stall only holds the upstream stages
    dest_stage_reg #(.W(REG_ADDR_W + 1)) u_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .d     ({mem_dest, mem_reg_write}),
        .q     (wb_q)
    );

    assign {wb_dest, wb_reg_write} = wb_q;

    logic mem_live, wb_live;

    always_comb begin
        mem_live = mem_reg_write && mem_dest != ZERO;
        wb_live  = wb_reg_write && wb_dest != ZERO;
        fwd_a    = fwd_pick(mem_live && mem_dest == ex_rs, wb_live && wb_dest == ex_rs);
        fwd_b    = fwd_pick(mem_live && mem_dest == ex_rt, wb_live && wb_dest == ex_rt);
    end

endmodule

// File: tb/tb_dest_reg_tracker.sv
// tb_dest_reg_tracker: table-driven check of stage copies, forwarding selects and load-use stall
module tb_dest_reg_tracker;

`ifdef DEST_TRACK_LOAD_USE_EN
    localparam bit LU = 1'b1;
`else
    localparam bit LU = 1'b0;
`endif

    logic       clk, rst_n;
    logic [4:0] ex_dest, ex_rs, ex_rt, id_rs, id_rt;
    logic       ex_reg_write, ex_mem_read, ex_flush, id_uses_rt;
    logic [4:0] mem_dest, wb_dest;
    logic       mem_reg_write, wb_reg_write, stall;
    logic [1:0] fwd_a, fwd_b;

    dest_reg_tracker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_dest       (ex_dest),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_flush      (ex_flush),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .mem_dest      (mem_dest),
        .wb_dest       (wb_dest),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // st is the stall expected with the load-use check built in
    typedef struct {
        logic [4:0] dest;
        logic       we, rd, fl;
        logic [4:0] rs, rt, irs, irt;
        logic       ut;
        logic [1:0] fa, fb;
        logic       st;
    } vec_t;

    typedef struct packed {
        logic [4:0] d;
        logic       w;
    } stg_t;

    vec_t tbl[17];
    stg_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_dest      = v.dest;
        ex_reg_write = v.we;
        ex_mem_read  = v.rd;
        ex_flush     = v.fl;
        ex_rs        = v.rs;
        ex_rt        = v.rt;
        id_rs        = v.irs;
        id_rt        = v.irt;
        id_uses_rt   = v.ut;
    endtask

    task automatic step(input int i, input vec_t v);
        stg_t e;
        @(negedge clk);
        drive(v);
        #1;
        chk($sformatf("fwd_a[%0d]", i), {6'd0, fwd_a}, {6'd0, v.fa});
        chk($sformatf("fwd_b[%0d]", i), {6'd0, fwd_b}, {6'd0, v.fb});
        chk($sformatf("stall[%0d]", i), {7'd0, stall}, {7'd0, v.st & LU});
        e.d = v.fl ? 5'd0 : v.dest;
        e.w = v.fl ? 1'b0 : v.we;
        sb.push_back(e);
        @(posedge clk);
        #1;
        chk($sformatf("mem_dest[%0d]", i), {3'd0, mem_dest}, {3'd0, sb[$].d});
        chk($sformatf("mem_we[%0d]", i), {7'd0, mem_reg_write}, {7'd0, sb[$].w});
        if (sb.size() == 2) begin
            chk($sformatf("wb_dest[%0d]", i), {3'd0, wb_dest}, {3'd0, sb[0].d});
            chk($sformatf("wb_we[%0d]", i), {7'd0, wb_reg_write}, {7'd0, sb[0].w});
            void'(sb.pop_front());
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_mem_dest"}, {3'd0, mem_dest}, 8'd0);
        chk({tag, "_wb_dest"}, {3'd0, wb_dest}, 8'd0);
        chk({tag, "_mem_we"}, {7'd0, mem_reg_write}, 8'd0);
        chk({tag, "_wb_we"}, {7'd0, wb_reg_write}, 8'd0);
        chk({tag, "_fwd_a"}, {6'd0, fwd_a}, 8'd0);
        chk({tag, "_fwd_b"}, {6'd0, fwd_b}, 8'd0);
        chk({tag, "_stall"}, {7'd0, stall}, 8'd0);
    endtask

    vec_t hz, zv;
    stg_t z;

    initial begin
        //         dest we rd fl  rs rt irs irt ut  fa fb st
        tbl[0]  = '{3, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0};
        tbl[1]  = '{9, 1, 0, 0,  3, 4, 0, 0, 0,  2, 0, 0};
        tbl[2]  = '{6, 1, 0, 0,  9, 3, 0, 0, 0,  2, 1, 0};
        tbl[3]  = '{5, 1, 0, 0,  6, 9, 0, 0, 0,  2, 1, 0};
        tbl[4]  = '{5, 1, 0, 0,  1, 1, 0, 0, 0,  0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0,  5, 5, 0, 0, 0,  2, 2, 0};
        tbl[6]  = '{7, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0};
        tbl[7]  = '{8, 1, 0, 0,  7, 0, 0, 0, 0,  0, 0, 0};
        tbl[8]  = '{7, 1, 1, 0,  0, 0, 2, 7, 1,  0, 0, 1};
        tbl[9]  = '{7, 1, 1, 0,  8, 7, 2, 7, 0,  1, 2, 0};
        tbl[10] = '{0, 1, 1, 0,  7, 2, 0, 0, 0,  2, 0, 0};
        tbl[11] = '{4, 1, 1, 1,  0, 7, 4, 0, 0,  0, 1, 0};
        tbl[12] = '{2, 0, 0, 0,  4, 0, 4, 0, 0,  0, 0, 0};
        tbl[13] = '{4, 1, 1, 0,  2, 4, 4, 0, 0,  0, 0, 1};
        tbl[14] = '{9, 1, 0, 0,  4, 2, 9, 0, 0,  2, 0, 0};
        tbl[15] = '{9, 1, 0, 0,  4, 9, 0, 0, 0,  1, 2, 0};
        tbl[16] = '{9, 1, 0, 0,  9, 9, 0, 0, 0,  2, 2, 0};
        hz      = '{9, 1, 1, 0,  9, 9, 9, 0, 0,  2, 2, 1};
        zv      = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0};
        z       = '0;

        // power-on reset with a hazardous-looking instruction on the inputs
        rst_n = 1'b0;
        drive(hz);
        #12;
        chk_cleared("por");
        drive(zv);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(z);

        for (int i = 0; i < 17; i++) step(i, tbl[i]);

        // mem=wb=$9 now; assert reset between edges and expect an immediate clear
        @(negedge clk);
        drive(hz);
        #1;
        chk("pre_rst_fwd_a", {6'd0, fwd_a}, 8'd2);
        chk("pre_rst_fwd_b", {6'd0, fwd_b}, 8'd2);
        chk("pre_rst_stall", {7'd0, stall}, {7'd0, LU});
        #1;
        rst_n = 1'b0;
        #1;
        chk_cleared("rst_mid");
        @(posedge clk);
        #1;
        chk_cleared("rst_edge");

        // first edge after release loads straight away
        rst_n = 1'b1;
        sb.delete();
        sb.push_back(z);
        step(100, '{11, 1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0});
        step(101, '{12, 1, 0, 0, 11, 0, 0, 0, 0, 2, 0, 0});
        step(102, '{0, 0, 0, 0, 12, 11, 0, 0, 0, 2, 1, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dest_reg_tracker.md
# dest_reg_tracker

Tracks the destination-register number chosen by the RegDst mux (rt/rd select) through the EX/MEM and MEM/WB stages of the 5-stage MIPS pipeline. It sits directly downstream of the RegDst mux in EX. From its stage copies it drives the register-file write address, the ALU operand forwarding selects, and the load-use stall request to the IF/ID stage.

## Interface
- REG_ADDR_W, 5, register-number width
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_dest  input  REG_ADDR_W  destination register from the RegDst mux for the instruction in EX
- ex_reg_write  input  1  instruction in EX writes the register file
- ex_mem_read  input  1  instruction in EX is a load
- ex_flush  input  1  squash the instruction in EX (taken branch/jump)
- ex_rs, ex_rt  input  REG_ADDR_W  source registers of the instruction in EX
- id_rs, id_rt  input  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rt  input  1  instruction in ID reads rt as a source
- mem_dest, wb_dest  output  REG_ADDR_W  destination held in the MEM and WB stage copies
- mem_reg_write, wb_reg_write  output  1  write-enable held in the MEM and WB stage copies; wb_* drives the register-file write port
- fwd_a, fwd_b  output  2  ALU operand A (rs) and B (rt) source select
- stall  output  1  load-use hazard: hold PC and IF/ID, insert a bubble into ID/EX

## Operation
- MEM copy = {dest, reg_write, mem_read}. It loads from the ex_* inputs every clock.
- When ex_flush=1 the MEM copy loads {0,0,0} instead.
- WB copy = {dest, reg_write}. It loads from the MEM copy every clock. It is never frozen; `stall` affects only upstream stages.
- Forwarding, operand A (operand B is identical with ex_rt):
  - 2'b10 (from MEM) if mem_reg_write && mem_dest!=0 && mem_dest==ex_rs.
  - Otherwise 2'b01 (from WB) if wb_reg_write && wb_dest!=0 && wb_dest==ex_rs.
  - Otherwise 2'b00 (register file).
- Same register in both MEM and WB: MEM wins (it is the younger write).
- Register $0 never forwards and never stalls.
- stall = ex_mem_read && ex_reg_write && ex_dest!=0 && (ex_dest==id_rs || (id_uses_rt && ex_dest==id_rt)).
- ex_flush=1 forces stall=0. A squashed load does not stall.
- fwd 2'b11 is never produced.
- No wrap-around or overflow conditions exist. All comparisons are full REG_ADDR_W equality.

## Timing
- Reset (rst_n low, asynchronous, effective mid-cycle): both stage copies clear to zero.
  - mem_dest=0, wb_dest=0, mem_reg_write=0, wb_reg_write=0.
  - fwd_a=fwd_b=2'b00 and stall=0 regardless of inputs, since they are qualified by the cleared enables.
- Latency: ex_dest appears on mem_dest 1 cycle after the sampling edge and on wb_dest after 2 cycles.
- fwd_a, fwd_b and stall are combinational from current inputs and the stage copies. They are valid in the same cycle and have no registered delay.
- Simultaneous flush and load-use hazard: flush wins (stall=0, MEM copy cleared).
- Reset released mid-operation: the first edge after release loads normally. No extra warm-up cycle.

## Configuration
- DEST_TRACK_LOAD_USE_EN defined: `stall` is generated as specified above.
- DEST_TRACK_LOAD_USE_EN undefined:
  - stall is tied to 0 and mem_read is not stored.
  - Software scheduling (NOP after load) is relied on.
  - Forwarding is unchanged.

## Structure
- Shared package `pipe_pkg`:
  - constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, REG_ZERO=0.
  - a typedef for the fwd_sel 2-bit type.
- One natural sub-module, `dest_stage_reg`: a single stage copy with async active-low clear and a synchronous clear input. Instantiated twice (MEM with ex_flush as clear; WB with clear tied 0).
- Forwarding and stall compare logic stays in the top module.

## Test plan
- Reset mid-run:
  - Stimulus: with mem_dest=9 and wb_dest=9 loaded, drive rst_n low between edges.
  - Response: within the same cycle, mem_dest=wb_dest=0, both reg_write outputs=0, fwd_a=fwd_b=00, stall=0.
- MEM forward:
  - Stimulus: cycle 0 ex_dest=3, ex_reg_write=1. Cycle 1 ex_rs=3, ex_rt=4.
  - Response: cycle 1 fwd_a=10, fwd_b=00.
- WB forward and priority:
  - Stimulus 1: cycle 0 ex_dest=3 write, cycle 1 other write, cycle 2 ex_rt=3.
  - Response 1: cycle 2 fwd_b=01.
  - Stimulus 2: two consecutive writes to $5, then ex_rs=5.
  - Response 2: fwd_a=10.
- $0 filter:
  - Stimulus: ex_dest=0, ex_reg_write=1, then ex_rs=0.
  - Response: fwd_a=00.
  - Stimulus: load with ex_dest=0 and id_rs=0.
  - Response: stall=0.
- Load-use:
  - Stimulus: ex_mem_read=1, ex_reg_write=1, ex_dest=7, id_rt=7, id_uses_rt=1.
  - Response: stall=1.
  - Stimulus: same, with id_uses_rt=0 and id_rs=2.
  - Response: stall=0.
  - Stimulus: macro undefined.
  - Response: stall=0 in all cases.
- Flush:
  - Stimulus: ex_dest=4, ex_reg_write=1, ex_mem_read=1, ex_flush=1, id_rs=4.
  - Response: stall=0 that cycle. Next cycle mem_reg_write=0, mem_dest=0; ex_rs=4 gives fwd_a=00.
